// File: rtl/slc3_mem_bridge.sv
// SLC-3 memory/I-O bridge: turns single-beat MAR/MDR requests into sequenced
// active-low SRAM strobes and maps IO_ADDR onto the switches and hex register.
module slc3_mem_bridge #(
  parameter int          READ_WAIT = 2,        // 1..7
  parameter logic [15:0] IO_ADDR   = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_Req,
  input  logic        Mem_RW,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_In,
  output logic        Ready,
  output logic [15:0] Data_to_CPU,
  input  logic [15:0] S,
  output logic [15:0] HEX_Data,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        Data_oe,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE
);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(READ_WAIT - 1);

  state_t      state, next_state;
  logic [2:0]  wait_cnt, next_cnt;
  logic        armed;
  logic [15:0] s_meta, s_sync;
  logic        ce_q;
  logic        accept, io_hit, rd_done;
  logic        ce_nx, oe_nx, we_nx, doe_nx, ready_nx;

  assign io_hit = (MAR == IO_ADDR);

  // Byte lanes are always enabled together with the chip.
  assign CE = ce_q;
  assign UB = ce_q;
  assign LB = ce_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    accept     = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_Req && armed) begin
          accept = 1'b1;
          if (io_hit) begin
            next_state = DONE;
          end else if (Mem_RW) begin
            next_state = WR_SETUP;
          end else begin
            next_state = RD_WAIT;
            next_cnt   = WAIT_LOAD;
          end
        end
      end
      RD_WAIT: begin
        if (wait_cnt == 3'd0) begin
          next_state = DONE;
          rd_done    = 1'b1;
        end else begin
          next_cnt = wait_cnt - 3'd1;
        end
      end
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: next_state = WR_HOLD;
      WR_HOLD:  next_state = DONE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase

    // Strobes are decoded from the next state so the registered copies line
    // up with the state they belong to and only ever change on a clock edge.
    ce_nx    = 1'b1;
    oe_nx    = 1'b1;
    we_nx    = 1'b1;
    doe_nx   = 1'b0;
    ready_nx = 1'b0;
    case (next_state)
      RD_WAIT: begin
        ce_nx = 1'b0;
        oe_nx = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_nx  = 1'b0;
        doe_nx = 1'b1;
      end
      WR_PULSE: begin
        ce_nx  = 1'b0;
        we_nx  = 1'b0;
        doe_nx = 1'b1;
      end
      DONE:    ready_nx = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      armed        <= 1'b0;
      s_meta       <= 16'h0000;
      s_sync       <= 16'h0000;
      ADDR         <= 20'h00000;
      Data_to_SRAM <= 16'h0000;
      Data_to_CPU  <= 16'h0000;
      HEX_Data     <= 16'h0000;
      Ready        <= 1'b0;
      ce_q         <= 1'b1;
      OE           <= 1'b1;
      WE           <= 1'b1;
      Data_oe      <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      s_meta   <= S;
      s_sync   <= s_meta;
      Ready    <= ready_nx;
      ce_q     <= ce_nx;
      OE       <= oe_nx;
      WE       <= we_nx;
      Data_oe  <= doe_nx;

      // A request must be seen low before it can start another access.
      if (accept)        armed <= 1'b0;
      else if (!Mem_Req) armed <= 1'b1;

      // The access direction is carried by the state path taken at acceptance.
      if (accept) begin
        ADDR         <= {4'h0, MAR};
        Data_to_SRAM <= MDR_In;
        if (io_hit && Mem_RW)  HEX_Data    <= MDR_In;
        if (io_hit && !Mem_RW) Data_to_CPU <= s_sync;
      end
      if (rd_done) Data_to_CPU <= Data_from_SRAM;
    end
  end

endmodule

// File: doc/slc3_mem_bridge.md
# slc3_mem_bridge

Memory/I-O bridge between the SLC-3 datapath and the board SRAM plus the switch/hex peripherals. It sits directly downstream of the CPU's MAR/MDR memory port. It converts single-beat CPU read/write requests into correctly sequenced active-low SRAM strobes, and maps address xFFFF to the switches (read) and the hex-display register (write). It returns a one-cycle Ready pulse per completed access.

## Interface
Parameters:
- READ_WAIT, 2, cycles OE/CE are held low before SRAM read data is sampled (1..7)
- IO_ADDR, 16'hFFFF, address decoded as the I/O port

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- Mem_Req  in  1  CPU access request (level)
- Mem_RW  in  1  1 = write, 0 = read; sampled at acceptance
- MAR  in  16  CPU address; sampled at acceptance
- MDR_In  in  16  CPU write data; sampled at acceptance
- Ready  out  1  one-cycle completion pulse
- Data_to_CPU  out  16  read result; held until the next read completes
- S  in  16  board switches (asynchronous)
- HEX_Data  out  16  value shown on hex displays
- ADDR  out  20  SRAM address = {4'h0, latched MAR}
- Data_to_SRAM  out  16  SRAM write data
- Data_from_SRAM  in  16  SRAM read data
- Data_oe  out  1  1 = drive SRAM data bus (tri-state enable at top level)
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low

## Operation
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- Arming: the armed flag sets whenever Mem_Req is seen low and clears on acceptance. IDLE accepts only when Mem_Req=1 and armed=1. A request held high across Ready therefore never starts a second access.
- On acceptance: latch MAR, MDR_In, and Mem_RW.
- I/O read (MAR==IO_ADDR, RW=0): Data_to_CPU <= synchronized switches. Go to DONE. No SRAM strobes.
- I/O write (MAR==IO_ADDR, RW=1): HEX_Data <= MDR_In. Go to DONE. No SRAM strobes.
- SRAM read: enter RD_WAIT with a wait counter loaded to READ_WAIT-1.
  - While in RD_WAIT: CE=OE=UB=LB=0, WE=1, Data_oe=0.
  - When the counter reaches 0: Data_to_CPU <= Data_from_SRAM, then go to DONE.
- SRAM write:
  - WR_SETUP: CE=UB=LB=0, WE=1, Data_oe=1.
  - WR_PULSE: WE=0, Data_oe=1.
  - WR_HOLD: WE=1, Data_oe=1.
  - Then DONE. OE=1 throughout.
- DONE: Ready=1 for this cycle only, all strobes inactive, then IDLE.
- Strobe defaults outside the states above: CE=UB=LB=OE=WE=1, Data_oe=0.
- OE and WE are never both low. Data_oe is never 1 while OE=0.
- Switch path: 2-flop synchronizer on S. Reads see the value from 2 edges earlier.

## Timing
- Reset values: Ready=0, Data_to_CPU=0, HEX_Data=0, ADDR=0, Data_to_SRAM=0, Data_oe=0, CE=UB=LB=OE=WE=1, state=IDLE, armed=0, synchronizer=0.
- Latency, with acceptance at edge k:
  - I/O access: Ready high in cycle k+1.
  - SRAM read: Ready high in cycle k+READ_WAIT+1.
  - SRAM write: Ready high in cycle k+4.
- Data_to_CPU is valid in the same cycle Ready is high.
- Outputs are registered; strobes change only on clock edges.
- Back-to-back: after Ready, the next access needs at least one cycle of Mem_Req=0. Minimum request-to-request spacing is latency+2.
- Reset mid-access: at the reset edge all strobes return inactive and Data_oe=0. No Ready is issued, the in-flight access is discarded, and SRAM contents are undefined only for an interrupted WR_PULSE.
- Mem_RW, MAR, and MDR_In changing after acceptance have no effect.
- Mem_Req rising in the same cycle as Reset is ignored.

## Test plan
- Reset: assert Reset 1 cycle mid-WR_PULSE. Next cycle: WE=1, CE=1, Data_oe=0, Ready=0, HEX_Data=0, state IDLE.
- I/O path:
  - S=16'h000B, wait 3 cycles, read xFFFF: Ready at k+1 with Data_to_CPU=16'h000B.
  - Write xFFFF with 16'hA0A0: HEX_Data=16'hA0A0 at k+1, CE stays 1.
- SRAM write then read, READ_WAIT=2:
  - Write 16'h1234 to x0031: WE low exactly 1 cycle (k+2), Data_oe high for cycles k+1..k+3, ADDR=20'h00031, Ready at k+4.
  - Read x0031 (model returns stored data): OE low 2 cycles, Ready at k+3, Data_to_CPU=16'h1234.
- Held request: keep Mem_Req=1 for 20 cycles after a read of x0000. Exactly one Ready pulse. Drop Mem_Req 1 cycle, reassert: a second access starts.
- Strobe checker: over 200 random accesses, OE&WE never both 0, Data_oe never 1 with OE=0, UB/LB track CE, one Ready per accepted request.
